mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the core's single memory port between the instruction-fetch stage (IF) and the memory-access stage (MA).
- Accepts one command at a time from either requester via a valid/ready handshake.
- Drives the registered memory address, write-data and write-enable.
- Waits out the fixed synchronous-read latency, then returns read data with a one-cycle done pulse to the requester that owns the command.
- Sits between the pipeline stages and the memory interface of the core.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
READ_LAT, 1, memory cycles from address presented to read data valid (legal 1..4)
MA_STREAK_MAX, 4, consecutive contested MA grants before IF is forced a grant (only with fairness feature)

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  IF command valid; held until accepted
if_addr  in  ADDR_W  IF fetch address
if_ready  out  1  IF command accepted this cycle when if_req=1
if_done  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched instruction
ma_req  in  1  MA command valid; held until accepted
ma_we  in  1  1 = store, 0 = load
ma_addr  in  ADDR_W  MA address
ma_wdata  in  DATA_W  store data
ma_ready  out  1  MA command accepted this cycle when ma_req=1
ma_done  out  1  one-cycle pulse; load data valid or store complete
ma_rdata  out  DATA_W  load data (undefined for stores)
mem_addr  out  ADDR_W  registered address to memory
mem_wdata  out  DATA_W  registered write data
mem_we  out  1  registered write enable
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; mem_addr=0, mem_wdata=0, mem_we=0; if_done=0, ma_done=0; if_rdata=0, ma_rdata=0; lat_cnt=0; owner=IF; streak=0.
- States: IDLE, ISSUE, WAIT, DONE.
- Ready signals are combinational and can be high only in IDLE:
  - ma_ready = ma_req & ~force_if.
  - if_ready = if_req & (~ma_req | force_if).
  - Without the fairness feature, force_if is always 0.
- Acceptance in IDLE (edge ending cycle T): latch owner; mem_addr<=addr; mem_we<=ma_we (MA only, else 0); mem_wdata<=ma_wdata; go to ISSUE.
- ISSUE (cycle T+1): memory sees the command.
  - Store: mem_we=1 for exactly this cycle; next state DONE; mem_we<=0.
  - Load/fetch: lat_cnt<=READ_LAT-1; go to WAIT if READ_LAT>1, else capture mem_rdata at the end of cycle T+1+READ_LAT... (see WAIT).
- WAIT: decrement lat_cnt. When lat_cnt==0, mem_rdata is valid this cycle; capture it into the owner's rdata register and go to DONE.
  - READ_LAT=1: capture at end of cycle T+2. Done pulse in cycle T+3.
  - General: done in cycle T+2+READ_LAT for reads, T+2 for stores.
- DONE: owner's done=1 for one cycle; the non-owner done stays 0; return to IDLE. No acceptance in DONE.
- Back-to-back: the earliest next acceptance is the cycle after DONE. Throughput is one command per 3+READ_LAT cycles (reads) or 3 cycles (stores).
- rdata registers hold their last value until overwritten by a new read for the same requester.
- mem_addr and mem_wdata hold their values outside ISSUE. mem_we is 1 only in ISSUE of a store.
- Requests are sampled only in IDLE. Requester changes while busy are ignored. A requester must keep addr/data stable while req=1 and not yet ready.
- Reset mid-operation: immediate return to IDLE, mem_we forced 0, the in-flight command is dropped, no done pulse is issued.

Optional Feature:
MEM_ARB_FAIRNESS_EN
- Defined: a streak counter (width $clog2(MA_STREAK_MAX+1)) increments on each MA acceptance made while if_req=1. It resets to 0 on any IF acceptance or on an MA acceptance while if_req=0.
  - force_if = (streak==MA_STREAK_MAX) & if_req, so IF wins that contest.
- Undefined: streak logic is absent; MA always has strict priority and IF can starve under continuous MA traffic.

Decomposition:
- Shared package core_pkg: ADDR_W/DATA_W defaults; state enum (IDLE, ISSUE, WAIT, DONE); owner encoding (OWN_IF=0, OWN_MA=1).
- One natural sub-module, arb_pick: combinational priority/fairness select producing if_ready, ma_ready and next streak.
- FSM and datapath registers stay in mem_port_arbiter.

Test Plan:
- Single IF fetch, READ_LAT=1: if_req=1, if_addr=0x0010 in cycle 0, memory returns 0xBEEF -> if_ready=1 in cycle 0; mem_addr=0x0010 in cycle 1; if_done=1, if_rdata=0xBEEF in cycle 3; ma_done stays 0.
- MA store: ma_req=1, ma_we=1, addr 0x0200, wdata 0x1234 -> mem_we=1 only in cycle 1 with mem_addr=0x0200, mem_wdata=0x1234; ma_done pulse in cycle 2.
- Simultaneous if_req and ma_req (load 0x0300) -> ma_ready=1, if_ready=0; IF accepted in the first IDLE cycle after ma_done; IF fetch completes correctly.
- READ_LAT=3 load -> ma_done exactly 5 cycles after acceptance; mem_rdata value from cycle T+4 is captured; other cycle values are ignored.
- Fairness: with MEM_ARB_FAIRNESS_EN, MA_STREAK_MAX=4, both requesting continuously -> grant order MA,MA,MA,MA,IF,MA... Without the macro -> IF is never granted while ma_req=1.
- rst asserted during WAIT of a fetch -> mem_we=0 and state IDLE immediately; no if_done pulse; a fresh request after rst deassert completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MA memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int LAT_W      = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_MA = 1'b1} owner_t;

  // The latency counter counts down to zero, so it is loaded with one less than the latency.
  function automatic logic [LAT_W-1:0] lat_load(input int read_lat);
    return LAT_W'(read_lat - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant select for the memory-port arbiter; MA has priority.
// With MEM_ARB_FAIRNESS_EN defined, a streak of contested MA grants forces one IF grant.
module arb_pick
`ifdef MEM_ARB_FAIRNESS_EN
#(
  parameter int MA_STREAK_MAX = 4,
  parameter int STREAK_W      = $clog2(MA_STREAK_MAX + 1)
)
`endif
(
  input  logic                idle,
  input  logic                if_req,
  input  logic                ma_req,
`ifdef MEM_ARB_FAIRNESS_EN
  input  logic [STREAK_W-1:0] streak,
  output logic [STREAK_W-1:0] streak_nxt,
`endif
  output logic                if_ready,
  output logic                ma_ready
);

  logic force_if;

`ifdef MEM_ARB_FAIRNESS_EN
  assign force_if = (streak == STREAK_W'(MA_STREAK_MAX)) & if_req;

  // Only MA wins taken while IF was waiting extend the streak.
  always_comb begin
    streak_nxt = streak;
    if (if_ready)
      streak_nxt = '0;
    else if (ma_ready)
      streak_nxt = if_req ? streak + 1'b1 : '0;
  end
`else
  assign force_if = 1'b0;
`endif

  assign ma_ready = idle & ma_req & ~force_if;
  assign if_ready = idle & if_req & (~ma_req | force_if);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and memory access.
// Optional fairness (IF anti-starvation) is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int READ_LAT      = 1,
  parameter int MA_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic              ma_ready,
  output logic              ma_done,
  output logic [DATA_W-1:0] ma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t           state;
  owner_t           owner;
  logic [LAT_W-1:0] lat_cnt;
  logic             idle;

  assign idle = (state == IDLE);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(MA_STREAK_MAX + 1);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;

  arb_pick #(
    .MA_STREAK_MAX(MA_STREAK_MAX)
  ) u_pick (
    .idle      (idle),
    .if_req    (if_req),
    .ma_req    (ma_req),
    .streak    (streak),
    .streak_nxt(streak_nxt),
    .if_ready  (if_ready),
    .ma_ready  (ma_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      streak <= '0;
    else if (if_ready | ma_ready)
      streak <= streak_nxt;
  end
`else
  arb_pick u_pick (
    .idle    (idle),
    .if_req  (if_req),
    .ma_req  (ma_req),
    .if_ready(if_ready),
    .ma_ready(ma_ready)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lat_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      if_done   <= 1'b0;
      ma_done   <= 1'b0;
      if_rdata  <= '0;
      ma_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      ma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ma_ready) begin
            owner     <= OWN_MA;
            mem_addr  <= ma_addr;
            mem_wdata <= ma_wdata;
            mem_we    <= ma_we;
            state     <= ISSUE;
          end else if (if_ready) begin
            owner    <= OWN_IF;
            mem_addr <= if_addr;
            mem_we   <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // Stores only come from MA and complete as soon as memory has seen the write.
          if (mem_we) begin
            mem_we  <= 1'b0;
            ma_done <= 1'b1;
            state   <= DONE;
          end else begin
            lat_cnt <= lat_load(READ_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            if (owner == OWN_MA) begin
              ma_rdata <= mem_rdata;
              ma_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized traffic
// against a transaction-level timing/data model; a second READ_LAT=3 instance checks latency.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int RL = 1;
  localparam int SMAX = 4;

  logic        clk;
  logic        rst;
  logic        if_req, ma_req, ma_we;
  logic [15:0] if_addr, ma_addr, ma_wdata, mem_rdata;
  logic        if_ready, if_done, ma_ready, ma_done, mem_we;
  logic [15:0] if_rdata, ma_rdata, mem_addr, mem_wdata;

  logic        l_if_req, l_ma_req, l_ma_we;
  logic [15:0] l_if_addr, l_ma_addr, l_ma_wdata, l_mem_rdata;
  logic        l_if_ready, l_if_done, l_ma_ready, l_ma_done, l_mem_we;
  logic [15:0] l_if_rdata, l_ma_rdata, l_mem_addr, l_mem_wdata;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(RL), .MA_STREAK_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_done(if_done), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_ready(ma_ready), .ma_done(ma_done), .ma_rdata(ma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3), .MA_STREAK_MAX(SMAX)) u_lat3 (
    .clk(clk), .rst(rst),
    .if_req(l_if_req), .if_addr(l_if_addr), .if_ready(l_if_ready), .if_done(l_if_done), .if_rdata(l_if_rdata),
    .ma_req(l_ma_req), .ma_we(l_ma_we), .ma_addr(l_ma_addr), .ma_wdata(l_ma_wdata),
    .ma_ready(l_ma_ready), .ma_done(l_ma_done), .ma_rdata(l_ma_rdata),
    .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata), .mem_we(l_mem_we), .mem_rdata(l_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {a, ~a} ^ 16'h3C5A;
  endfunction

  // Synchronous RAM with one-cycle read latency for the main instance.
  logic [15:0] ram [256];
  bit          wr_mask [256];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[7:0]]     <= mem_wdata;
      wr_mask[mem_addr[7:0]] <= 1'b1;
    end
    mem_rdata <= wr_mask[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ref_mem [256];
  int          cyc, free_at, issue_at, done_at, streak;
  bit          t_ma, t_we, rec;
  logic [15:0] t_addr, t_wdata, t_data, e_if_rdata, e_ma_rdata;
  bit          grants [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_if(input logic [15:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic req_ma(input bit we, input logic [15:0] a, input logic [15:0] d);
    ma_req   = 1'b1;
    ma_we    = we;
    ma_addr  = a;
    ma_wdata = d;
  endtask

  // One cycle of the reference model: entered and left at #1 after a rising edge.
  task automatic run_cycle();
    bit idle, frc, e_mr, e_ir;
    @(negedge clk);
    idle = (cyc >= free_at);
    frc  = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
    frc = (streak == SMAX) && if_req;
`endif
    e_mr = idle && ma_req && !frc;
    e_ir = idle && if_req && (!ma_req || frc);
    chk("ma_ready", ma_ready, e_mr);
    chk("if_ready", if_ready, e_ir);
    if (cyc == done_at && !t_we) begin
      if (t_ma) e_ma_rdata = t_data;
      else      e_if_rdata = t_data;
    end
    chk("if_done", if_done, (cyc == done_at) && !t_ma);
    chk("ma_done", ma_done, (cyc == done_at) && t_ma);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("ma_rdata", ma_rdata, e_ma_rdata);
    chk("mem_we", mem_we, (cyc == issue_at) && t_we);
    if (cyc == issue_at) begin
      chk("mem_addr", mem_addr, t_addr);
      if (t_we) begin
        chk("mem_wdata", mem_wdata, t_wdata);
        ref_mem[t_addr[7:0]] = t_wdata;
      end
    end
    if (rec && (if_ready || ma_ready)) grants.push_back(if_ready);
    if (e_mr || e_ir) begin
      t_ma     = e_mr;
      t_we     = e_mr && ma_we;
      t_addr   = e_mr ? ma_addr : if_addr;
      t_wdata  = ma_wdata;
      t_data   = ref_mem[t_addr[7:0]];
      issue_at = cyc + 1;
      done_at  = cyc + (t_we ? 2 : 2 + RL);
      free_at  = done_at + 1;
      if (e_ir)        streak = 0;
      else if (if_req) streak = streak + 1;
      else             streak = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (e_mr) ma_req = 1'b0;
    if (e_ir) if_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((if_req || ma_req || cyc < free_at) && n < budget) begin
      run_cycle();
      n++;
    end
    chk("idle_budget", n < budget, 1'b1);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    if_req = 1'b0;
    ma_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_state", u_dut.state, IDLE);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_dones", {if_done, ma_done}, 2'b00);
    chk("rst_rdata", {if_rdata, ma_rdata}, 32'h0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    cyc        = cyc + 2;
    free_at    = cyc;
    issue_at   = -1;
    done_at    = -1;
    streak     = 0;
    e_if_rdata = '0;
    e_ma_rdata = '0;
  endtask

  initial begin
    logic [15:0] expv, a;
    logic [5:0]  g6, g6_exp;
    rst = 1'b1;
    {if_req, ma_req, ma_we} = '0;
    {if_addr, ma_addr, ma_wdata} = '0;
    {l_if_req, l_ma_req, l_ma_we} = '0;
    {l_if_addr, l_ma_addr, l_ma_wdata, l_mem_rdata} = '0;
    cyc = 0; free_at = 0; issue_at = -1; done_at = -1; streak = 0; rec = 1'b0;
    t_ma = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    @(posedge clk);
    #1;
    do_reset();

    // READ_LAT=3 instance: only the T+4 memory value may be captured.
    for (int n = 0; n < 2; n++) begin
      expv = 16'($urandom);
      a    = (n == 0) ? 16'h0400 : 16'($urandom);
      if (n == 0) begin l_ma_req = 1'b1; l_ma_we = 1'b0; l_ma_addr = a; end
      else        begin l_if_req = 1'b1; l_if_addr = a; end
      l_mem_rdata = ~expv;
      @(negedge clk);
      chk("l3_ready", {l_ma_ready, l_if_ready}, (n == 0) ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
      l_ma_req = 1'b0;
      l_if_req = 1'b0;
      for (int k = 1; k <= 7; k++) begin
        l_mem_rdata = (k == 4) ? expv : (expv ^ 16'(k * 16'h1111));
        @(negedge clk);
        if (k == 1) chk("l3_mem_addr", l_mem_addr, a);
        chk("l3_ma_done", l_ma_done, (k == 5) && (n == 0));
        chk("l3_if_done", l_if_done, (k == 5) && (n == 1));
        if (k >= 5) chk("l3_rdata", (n == 0) ? l_ma_rdata : l_if_rdata, expv);
        @(posedge clk);
        #1;
      end
    end

    req_if(16'h0010);
    repeat (5) run_cycle();
    chk("fetch_beef", if_rdata, 16'hBEEF);

    req_ma(1'b1, 16'h0200, 16'h1234);
    repeat (4) run_cycle();

    req_if(16'h0020);
    req_ma(1'b0, 16'h0300, 16'h0);
    wait_idle(30);
    req_ma(1'b0, 16'h0200, 16'h0);
    wait_idle(30);
    chk("store_readback", ma_rdata, 16'h1234);

    do_reset();
    rec = 1'b1;
    repeat (60) begin
      if (!if_req) req_if(16'($urandom));
      if (!ma_req) req_ma(1'($urandom), 16'($urandom), 16'($urandom));
      run_cycle();
    end
    rec = 1'b0;
    wait_idle(40);
    g6 = '1;
    if (grants.size() >= 6)
      for (int i = 0; i < 6; i++) g6[i] = grants[i];
`ifdef MEM_ARB_FAIRNESS_EN
    g6_exp = 6'b010000;
`else
    g6_exp = 6'b000000;
`endif
    chk("grant_order", g6, g6_exp);

    req_if(16'h0044);
    run_cycle();
    run_cycle();
    rst = 1'b1;
    #1;
    chk("midrst_state", u_dut.state, IDLE);
    chk("midrst_mem_we", mem_we, 1'b0);
    chk("midrst_if_done", if_done, 1'b0);
    do_reset();
    repeat (4) run_cycle();
    req_if(16'h0010);
    wait_idle(20);
    chk("post_rst_fetch", if_rdata, 16'hBEEF);

    req_ma(1'b1, 16'h0055, 16'hAAAA);
    run_cycle();
    chk("issue_mem_we", mem_we, 1'b1);
    rst = 1'b1;
    #1;
    chk("issue_rst_mem_we", mem_we, 1'b0);
    do_reset();
    req_ma(1'b0, 16'h0055, 16'h0);
    wait_idle(20);
    chk("dropped_store", ma_rdata, init_val(8'h55));

    repeat (300) begin
      if (!if_req && $urandom_range(0, 2) == 0) req_if(16'($urandom));
      if (!ma_req && $urandom_range(0, 2) == 0) req_ma(1'($urandom), 16'($urandom), 16'($urandom));
      run_cycle();
    end
    wait_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
